// File: rtl/mdu.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide.
// Optional MDU_FAST_MUL_EN replaces the iterative multiply with a one-cycle product.
module mdu #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic            i_kill,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state;
    logic [2:0]        op;
    logic [CNT_W-1:0]  cnt;
    logic              neg;
    logic [2*XLEN-1:0] prod;   // mul: {accumulator, multiplier}; div: low half dividend -> quotient
    logic [XLEN-1:0]   opb;    // multiplicand or divisor
    logic [XLEN-1:0]   rem;

    // Request decode
    logic            a_signed, b_signed, a_neg, b_neg, sign, b_zero, ovf;
    logic [XLEN-1:0] a_mag, b_mag, special;

    always_comb begin
        a_signed = (i_op == 3'b001) || (i_op == 3'b010) || (i_op[2] && !i_op[0]);
        b_signed = (i_op == 3'b001) || (i_op[2] && !i_op[0]);
        a_neg    = a_signed && i_a[XLEN-1];
        b_neg    = b_signed && i_b[XLEN-1];
        a_mag    = a_neg ? -i_a : i_a;
        b_mag    = b_neg ? -i_b : i_b;
        sign     = (i_op[2] && i_op[1]) ? a_neg : (a_neg ^ b_neg);
        b_zero   = (i_b == '0);
        ovf      = !i_op[0] && (i_a == MIN) && (i_b == '1);
        if (b_zero)
            special = i_op[1] ? i_a : '1;
        else
            special = i_op[1] ? '0 : MIN;
    end

    // One iteration step and the sign fix-up applied to its outcome
    logic [XLEN:0]     sum, shifted, diff;
    logic              ge;
    logic [2*XLEN-1:0] mul_next, prod_fix;
    logic [XLEN-1:0]   q_next, rem_next, q_fix, rem_fix, result_fix;

    always_comb begin
        sum      = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, opb} : '0);
        mul_next = {sum, prod[XLEN-1:1]};
        shifted  = {rem, prod[XLEN-1]};
        diff     = shifted - {1'b0, opb};
        ge       = !diff[XLEN];
        rem_next = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        q_next   = {prod[XLEN-2:0], ge};
        prod_fix = neg ? -mul_next : mul_next;
        q_fix    = neg ? -q_next : q_next;
        rem_fix  = neg ? -rem_next : rem_next;
        if (op[2])
            result_fix = op[1] ? rem_fix : q_fix;
        else
            result_fix = (op[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    end

`ifdef MDU_FAST_MUL_EN
    logic signed [XLEN:0]     fa, fb;
    logic signed [2*XLEN+1:0] fp;

    always_comb begin
        fa = {a_signed && i_a[XLEN-1], i_a};
        fb = {b_signed && i_b[XLEN-1], i_b};
        fp = fa * fb;
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            op       <= '0;
            cnt      <= '0;
            neg      <= 1'b0;
            prod     <= '0;
            opb      <= '0;
            rem      <= '0;
            o_result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid && !i_kill) begin
                        op  <= i_op;
                        neg <= sign;
                        if (i_op[2] && (b_zero || ovf)) begin
                            o_result <= special;
                            state    <= DONE;
                        end
`ifdef MDU_FAST_MUL_EN
                        else if (!i_op[2]) begin
                            o_result <= (i_op[1:0] == 2'b00) ? fp[XLEN-1:0] : fp[2*XLEN-1:XLEN];
                            state    <= DONE;
                        end
`endif
                        else begin
                            prod  <= {{XLEN{1'b0}}, i_op[2] ? a_mag : b_mag};
                            opb   <= i_op[2] ? b_mag : a_mag;
                            rem   <= '0;
                            cnt   <= CNT_W'(XLEN);
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (i_kill) begin
                        state <= IDLE;
                    end else begin
                        prod <= op[2] ? {prod[2*XLEN-1:XLEN], q_next} : mul_next;
                        rem  <= rem_next;
                        cnt  <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) begin
                            o_result <= result_fix;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (i_kill || i_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_ready = (state == IDLE);
    assign o_valid = (state == DONE);

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu (XLEN=32): directed table, random ops vs. an arithmetic
// model, backpressure, kill and reset recovery. Honours MDU_FAST_MUL_EN for latency.
module tb_mdu;

    logic        clk = 1'b0;
    logic        rst, valid, ready_o, kill, valid_o, ready;
    logic [2:0]  op;
    logic [31:0] a, b, result;

    int unsigned tests = 0;
    int unsigned fails = 0;

    mdu #(.XLEN(32)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_valid  (valid),
        .o_ready  (ready_o),
        .i_op     (op),
        .i_a      (a),
        .i_b      (b),
        .i_kill   (kill),
        .o_valid  (valid_o),
        .i_ready  (ready),
        .o_result (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference results straight from the RV32M definitions, using 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, ux, uy;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'b0, x});
        uy = longint'({32'b0, y});
        p  = '0;
        case (f)
            3'd0: begin p = 64'(ux * uy); return p[31:0];  end
            3'd1: begin p = 64'(sx * sy); return p[63:32]; end
            3'd2: begin p = 64'(sx * uy); return p[63:32]; end
            3'd3: begin p = 64'(ux * uy); return p[63:32]; end
            3'd4: begin if (y == 0) return 32'hFFFFFFFF; p = 64'(sx / sy); return p[31:0]; end
            3'd5: begin if (y == 0) return 32'hFFFFFFFF; return x / y; end
            3'd6: begin if (y == 0) return x; p = 64'(sx % sy); return p[31:0]; end
            default: begin if (y == 0) return x; return x % y; end
        endcase
    endfunction

    function automatic int unsigned latency(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        if (f[2] && (y == 0 || (!f[0] && x == 32'h80000000 && y == 32'hFFFFFFFF)))
            return 1;
`ifdef MDU_FAST_MUL_EN
        if (!f[2])
            return 1;
`endif
        return 33;
    endfunction

    // Called #1 after a rising edge; returns #1 after the edge that completed the handshake.
    task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp, input int unsigned hold);
        int unsigned k;
        logic        busy_bad, hold_bad;
        string       tag;
        tag = $sformatf("op%0d a=%08h b=%08h", f, x, y);
        op = f; a = x; b = y; valid = 1'b1;
        check({tag, " ready"}, {31'b0, ready_o}, 32'd1);
        @(posedge clk); #1;
        valid = 1'b0;
        op = 3'($urandom); a = $urandom; b = $urandom;
        k = 1;
        busy_bad = 1'b0;
        while (!valid_o && k < 100) begin
            if (ready_o) busy_bad = 1'b1;
            @(posedge clk); #1;
            k++;
        end
        if (!valid_o) begin
            check({tag, " timeout"}, 32'd0, 32'd1);
            return;
        end
        check({tag, " latency"}, k, latency(f, x, y));
        check({tag, " busy"}, {31'b0, busy_bad}, 32'd0);
        check({tag, " result"}, result, exp);
        hold_bad = 1'b0;
        for (int unsigned i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!valid_o || ready_o || result !== exp) hold_bad = 1'b1;
        end
        if (hold != 0) check({tag, " hold"}, {31'b0, hold_bad}, 32'd0);
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        check({tag, " release"}, {30'b0, ready_o, valid_o}, 32'd2);
    endtask

    task automatic start_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        op = f; a = x; b = y; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic watch_quiet(input string name);
        logic seen;
        seen = 1'b0;
        for (int unsigned i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (valid_o) seen = 1'b1;
        end
        check(name, {31'b0, seen}, 32'd0);
    endtask

    initial begin
        vec_t        vecs[12];
        logic [2:0]  f;
        logic [31:0] x, y;
        int unsigned wait_cnt;

        vecs[0]  = '{3'd0, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB};
        vecs[1]  = '{3'd1, 32'h80000000,  32'h80000000, 32'h40000000};
        vecs[2]  = '{3'd3, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[3]  = '{3'd2, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[4]  = '{3'd4, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD};
        vecs[5]  = '{3'd6, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF};
        vecs[6]  = '{3'd5, 32'd100,       32'd7,        32'd14};
        vecs[7]  = '{3'd7, 32'd100,       32'd7,        32'd2};
        vecs[8]  = '{3'd5, 32'd5,         32'd0,        32'hFFFFFFFF};
        vecs[9]  = '{3'd7, 32'd5,         32'd0,        32'd5};
        vecs[10] = '{3'd4, 32'h80000000,  32'hFFFFFFFF, 32'h80000000};
        vecs[11] = '{3'd6, 32'h80000000,  32'hFFFFFFFF, 32'd0};

        rst = 1'b1; valid = 1'b0; kill = 1'b0; ready = 1'b0;
        op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset state", {ready_o, valid_o, result[29:0]}, 32'h80000000);
        check("reset result", result, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table; the first entry also exercises 5 cycles of backpressure
        for (int i = 0; i < 12; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, (i == 0) ? 5 : 0);

        // Randomised ops against the model, biased toward zero and overflow divisors
        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom_range(0, 7));
            x = $urandom;
            case ($urandom_range(0, 7))
                0: y = '0;
                1: y = 32'($urandom_range(1, 15));
                2: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
                default: y = $urandom;
            endcase
            run_op(f, x, y, model(f, x, y), $urandom_range(0, 2));
        end

        // Kill ten cycles into CALC, then recover
        start_op(3'd5, 32'd1000, 32'd7);
        repeat (9) begin @(posedge clk); #1; end
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill to idle", {30'b0, ready_o, valid_o}, 32'd2);
        watch_quiet("kill no valid");
        run_op(3'd5, 32'd9, 32'd3, 32'd3, 0);

        // Reset mid-CALC, then recover
        start_op(3'd1, 32'h12345678, 32'h9ABCDEF0);
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst to idle", {30'b0, ready_o, valid_o}, 32'd2);
        watch_quiet("rst no valid");
        run_op(3'd5, 32'd9, 32'd3, 32'd3, 0);

        // Kill in IDLE outranks a valid request
        valid = 1'b1; kill = 1'b1; op = 3'd5; a = 32'd9; b = 32'd0;
        @(posedge clk); #1;
        valid = 1'b0; kill = 1'b0;
        check("idle kill blocks accept", {31'b0, ready_o}, 32'd1);
        watch_quiet("idle kill no valid");

        // Kill together with ready while DONE
        start_op(3'd5, 32'd50, 32'd0);
        wait_cnt = 0;
        while (!valid_o && wait_cnt < 100) begin @(posedge clk); #1; wait_cnt++; end
        check("done reached", {31'b0, valid_o}, 32'd1);
        kill = 1'b1; ready = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0; ready = 1'b0;
        check("kill+ready to idle", {30'b0, ready_o, valid_o}, 32'd2);
        run_op(3'd7, 32'd100, 32'd7, 32'd2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
